// File: rtl/vga_text_writer.sv
// Text-mode writer for a 40x30 character VRAM. Commands place characters
// at a hardware cursor, move the cursor, or clear the screen. A line feed
// or wrap past the last row scrolls the screen up by one row.
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while the FSM is IDLE,
// and the upstream holds the command stable until it is taken.
module vga_text_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    input  logic [2:0]  cmd_color,
    output logic        vram_we,
    output logic [10:0] vram_addr,
    output logic [18:0] vram_din,
    output logic        vram_re,
    input  logic [18:0] vram_rdata,
    output logic [4:0]  cursor_row,
    output logic [5:0]  cursor_col,
    output logic        busy
);

    localparam logic [18:0] BLANK    = 19'h00020;
    localparam logic [4:0]  LAST_ROW = 5'd29;
    localparam logic [5:0]  LAST_COL = 6'd39;
    localparam logic [15:0] CODE_LF  = 16'h000A;
    localparam logic [15:0] CODE_CR  = 16'h000D;
    localparam logic [15:0] CODE_BS  = 16'h0008;

    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLR} state_t;

    state_t      state, state_n;
    logic [4:0]  row_n;
    logic [5:0]  col_n;
    logic [4:0]  cell_row, cell_row_n;
    logic [5:0]  cell_col, cell_col_n;
    logic        we_n, re_n, ready_n;
    logic        put_bs, put_bs_n;
    logic        din_sel, din_sel_n;
    logic [10:0] addr_n;
    logic [18:0] din_q, din_n;
    logic        accept;
    logic [4:0]  cmd_row;
    logic [5:0]  cmd_col;

    assign accept  = cmd_valid && cmd_ready;
    assign cmd_row = cmd_data[10:6];
    assign cmd_col = cmd_data[5:0];
    assign busy    = ~cmd_ready;

    // Read data only arrives in the SCR_WR cycle itself, so during that cycle
    // it is forwarded straight onto the write data; otherwise din is a flop.
    assign vram_din = din_sel ? vram_rdata : din_q;

    // Next-state, cursor, cell-counter and registered-output computation.
    always_comb begin
        state_n    = state;
        row_n      = cursor_row;
        col_n      = cursor_col;
        cell_row_n = cell_row;
        cell_col_n = cell_col;
        put_bs_n   = put_bs;
        we_n       = 1'b0;
        re_n       = 1'b0;
        din_sel_n  = 1'b0;
        addr_n     = vram_addr;
        din_n      = din_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        2'b00: begin
                            if (cmd_data == CODE_LF) begin
                                col_n = 6'd0;
                                if (cursor_row == LAST_ROW) begin
                                    state_n    = SCR_RD;
                                    cell_row_n = 5'd0;
                                    cell_col_n = 6'd0;
                                    re_n       = 1'b1;
                                    addr_n     = {5'd1, 6'd0};
                                end else begin
                                    row_n = cursor_row + 5'd1;
                                end
                            end else if (cmd_data == CODE_CR) begin
                                col_n = 6'd0;
                            end else if (cmd_data == CODE_BS) begin
                                if (cursor_col != 6'd0) begin
                                    state_n  = PUT;
                                    put_bs_n = 1'b1;
                                    we_n     = 1'b1;
                                    addr_n   = {cursor_row, cursor_col - 6'd1};
                                    din_n    = BLANK;
                                end
                            end else begin
                                state_n  = PUT;
                                put_bs_n = 1'b0;
                                we_n     = 1'b1;
                                addr_n   = {cursor_row, cursor_col};
                                din_n    = {cmd_color, cmd_data};
                            end
                        end
                        2'b01: begin
                            if (cmd_row <= LAST_ROW && cmd_col <= LAST_COL) begin
                                row_n = cmd_row;
                                col_n = cmd_col;
                            end
                        end
                        2'b10: begin
                            state_n    = CLR;
                            cell_row_n = 5'd0;
                            cell_col_n = 6'd0;
                            we_n       = 1'b1;
                            addr_n     = 11'd0;
                            din_n      = BLANK;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            PUT: begin
                state_n = IDLE;
                if (put_bs) begin
                    col_n = cursor_col - 6'd1;
                end else if (cursor_col == LAST_COL) begin
                    col_n = 6'd0;
                    if (cursor_row == LAST_ROW) begin
                        state_n    = SCR_RD;
                        cell_row_n = 5'd0;
                        cell_col_n = 6'd0;
                        re_n       = 1'b1;
                        addr_n     = {5'd1, 6'd0};
                    end else begin
                        row_n = cursor_row + 5'd1;
                    end
                end else begin
                    col_n = cursor_col + 6'd1;
                end
            end
            SCR_RD: begin
                state_n   = SCR_WR;
                we_n      = 1'b1;
                din_sel_n = 1'b1;
                addr_n    = {cell_row, cell_col};
            end
            SCR_WR: begin
                state_n = SCR_RD;
                if (cell_col == LAST_COL) begin
                    cell_col_n = 6'd0;
                    if (cell_row == LAST_ROW - 5'd1) begin
                        state_n = SCR_CLR;
                    end else begin
                        cell_row_n = cell_row + 5'd1;
                    end
                end else begin
                    cell_col_n = cell_col + 6'd1;
                end
                if (state_n == SCR_RD) begin
                    re_n   = 1'b1;
                    addr_n = {cell_row_n + 5'd1, cell_col_n};
                end else begin
                    we_n   = 1'b1;
                    addr_n = {LAST_ROW, 6'd0};
                    din_n  = BLANK;
                end
            end
            SCR_CLR: begin
                if (cell_col == LAST_COL) begin
                    state_n = IDLE;
                end else begin
                    cell_col_n = cell_col + 6'd1;
                    we_n       = 1'b1;
                    addr_n     = {LAST_ROW, cell_col_n};
                    din_n      = BLANK;
                end
            end
            CLR: begin
                if (cell_col == LAST_COL) begin
                    cell_col_n = 6'd0;
                    if (cell_row == LAST_ROW) begin
                        state_n = IDLE;
                        row_n   = 5'd0;
                        col_n   = 6'd0;
                    end else begin
                        cell_row_n = cell_row + 5'd1;
                    end
                end else begin
                    cell_col_n = cell_col + 6'd1;
                end
                if (state_n == CLR) begin
                    we_n   = 1'b1;
                    addr_n = {cell_row_n, cell_col_n};
                    din_n  = BLANK;
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
    end

    // State, cursor, counters and all port registers; reset aborts any sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cursor_row <= 5'd0;
            cursor_col <= 6'd0;
            cell_row   <= 5'd0;
            cell_col   <= 6'd0;
            put_bs     <= 1'b0;
            vram_we    <= 1'b0;
            vram_re    <= 1'b0;
            vram_addr  <= 11'd0;
            din_q      <= 19'd0;
            din_sel    <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            state      <= state_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            cell_row   <= cell_row_n;
            cell_col   <= cell_col_n;
            put_bs     <= put_bs_n;
            vram_we    <= we_n;
            vram_re    <= re_n;
            vram_addr  <= addr_n;
            din_q      <= din_n;
            din_sel    <= din_sel_n;
            cmd_ready  <= ready_n;
        end
    end

endmodule

// File: doc/vga_text_writer.md
VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have ports clk (in, 1), the clock, and reset (in, 1), the reset; reset is asynchronous and active-high, and all logic is clocked on the rising edge of clk.
REQ-002 SHALL have cmd_valid (in, 1): a command is presented.
REQ-003 SHALL have cmd_ready (out, 1): the block accepts a command on this cycle.
REQ-004 SHALL have cmd_op (in, 2): 00 = put char, 01 = set cursor, 10 = clear screen, 11 = no-op.
REQ-005 SHALL have cmd_data (in, 16): the char code, or {5'b0, row[4:0], col[5:0]} for set cursor.
REQ-006 SHALL have cmd_color (in, 3): the RGB attribute for put char.
REQ-007 SHALL have vram_we (out, 1), vram_addr (out, 11), vram_din (out, 19) and vram_re (out, 1), forming the VRAM write/read port; vram_addr = {row[4:0], col[5:0]}.
REQ-008 SHALL have vram_rdata (in, 19): VRAM read data, valid one cycle after vram_re.
REQ-009 SHALL have cursor_row (out, 5), cursor_col (out, 6) and busy (out, 1).

Function
REQ-010 SHALL use a screen of 40 columns (0..39) by 30 rows (0..29); a VRAM word SHALL be {color[2:0], code[15:0]}, and the blank word SHALL be 19'h00020.
REQ-011 SHALL assert cmd_ready only in state IDLE; busy SHALL equal ~cmd_ready; a command is accepted on the cycle cmd_valid and cmd_ready are both high.
REQ-012 SHALL implement the states IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR and CLR, with every output registered.
REQ-013 SHALL handle put char with an ordinary code as follows: the block enters PUT; in the next cycle it drives vram_we=1 for one cycle with addr {row,col} and din {cmd_color,code}; it then advances col.
REQ-014 SHALL, when a put char is issued at col 39, wrap col to 0 and increment row.
REQ-015 SHALL handle code 16'h000A (LF) by setting col=0 and incrementing row, with no VRAM write.
REQ-016 SHALL handle code 16'h000D (CR) by setting col=0, with no VRAM write.
REQ-017 SHALL handle code 16'h0008 (BS) as follows: if col>0, decrement col and write the blank word at the new position; if col=0, do nothing and perform no write.
REQ-018 SHALL, when a row increment would make row 30, hold row at 29 and enter SCR_RD.
REQ-019 SHALL perform the scroll as follows. For each r in 0..28 and c in 0..39, in col-major-within-row order, SCR_RD asserts vram_re with addr {r+1,c}. The following SCR_WR cycle writes vram_rdata to {r,c}. Each cell takes 2 cycles, 2320 cycles in total.
REQ-020 SHALL then, in SCR_CLR, write the blank word to {29,0..39} at one cell per cycle (40 cycles), and then return to IDLE.
REQ-021 SHALL handle set cursor by loading row/col from cmd_data when row≤29 and col≤39, and SHALL otherwise ignore the command; the update SHALL be visible on cursor_row/col on the cycle after acceptance, and the block SHALL stay in IDLE.
REQ-022 SHALL handle clear screen by entering CLR and writing the blank word to all 1200 cells, rows 0..29 and cols 0..39 in row-major order, at one per cycle; it SHALL then set the cursor to (0,0) and return to IDLE.
REQ-023 SHALL treat no-op as accepted with no state change.
REQ-024 SHALL never write rows 30..31 or cols 40..63.
REQ-025 SHALL, when not writing, drive vram_we=0; SHALL, when not reading, drive vram_re=0; and vram_we and vram_re SHALL never be high in the same cycle.
REQ-026 SHALL not buffer commands; the upstream holds cmd_valid until cmd_ready.

Reset
REQ-027 SHALL, while reset=1, force the state to IDLE, cursor to (0,0), and vram_we=0, vram_re=0, vram_addr=0, vram_din=0 and cmd_ready=0.
REQ-028 SHALL drive cmd_ready=1 on the first clk edge after reset deasserts.
REQ-029 SHALL, on reset during a scroll or clear, abort immediately with no further VRAM writes; VRAM content is left partially updated.

Verification
REQ-030 SHALL cover: put 16'h0041 with color 3'b100 at (0,0) -> one write of addr 11'h000, din 19'h40041; cursor becomes (0,1); cmd_ready is low for 1 cycle.
REQ-031 SHALL cover: set cursor (5,39) then put 16'h0042 -> write addr {5,39}=11'h167; cursor becomes (6,0).
REQ-032 SHALL cover: cursor (29,10) with LF -> scroll occurs; {0,0} receives the old {1,0} contents; row 29 is all 19'h00020; busy lasts 2360 cycles; cursor becomes (29,0).
REQ-033 SHALL cover: BS at (3,0) -> no write and the cursor stays (3,0); BS at (3,4) -> write blank to {3,3} and the cursor becomes (3,3).
REQ-034 SHALL cover: clear screen -> 1200 writes of 19'h00020 with no addr having col>39 or row>29; the cursor ends at (0,0).
REQ-035 SHALL cover: reset asserted mid-clear at cell 500 -> vram_we goes low immediately; after release, cursor is (0,0) and cmd_ready=1.
